// File: rtl/relu_act_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | relu_act_pkg: mode codes, config record and saturation helper     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package relu_act_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_RELU   = 2'd1;
    localparam logic [1:0] MODE_CLIP   = 2'd2;
    localparam logic [1:0] MODE_LEAKY  = 2'd3;

    // Clip is held sign-extended so the record is independent of OUT_W.
    localparam int CFG_CLIP_W = 16;

    typedef struct packed {
        logic [1:0]            mode;
        logic [CFG_CLIP_W-1:0] clip;
        logic [2:0]            shift;
    } act_cfg_t;

    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] x,
        input int unsigned        w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_act_pipe_lane.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | relu_act_lane: one lane's activation (act_*) and sat/clip (sat_*) |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module relu_act_lane
    import relu_act_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]       act_x,
    input  logic [1:0]            act_mode,
    input  logic [2:0]            act_shift,
    output logic [IN_W-1:0]       act_a,
    input  logic [IN_W-1:0]       sat_a,
    input  logic [1:0]            sat_mode,
    input  logic [CFG_CLIP_W-1:0] sat_clip,
    output logic [OUT_W-1:0]      sat_y,
    output logic                  sat_flag
);

    logic signed [IN_W-1:0] w_x;
    logic signed [IN_W-1:0] w_shr;
    logic signed [31:0]     w_ext;
    logic signed [31:0]     w_sat;
    logic signed [31:0]     w_clip;

    assign w_x   = act_x;
    assign w_shr = w_x >>> act_shift;

    always_comb begin
        act_a = act_x;
        if ((act_mode != MODE_BYPASS) && w_x[IN_W-1])
            act_a = (act_mode == MODE_LEAKY) ? w_shr : '0;
    end

    assign w_ext    = {{(32-IN_W){sat_a[IN_W-1]}}, sat_a};
    assign w_sat    = sat_signed(w_ext, OUT_W);
    assign w_clip   = {{(32-CFG_CLIP_W){sat_clip[CFG_CLIP_W-1]}}, sat_clip};
    assign sat_flag = (w_sat != w_ext);

    // Clip is applied after saturation and is never counted as a saturation.
    always_comb begin
        sat_y = w_sat[OUT_W-1:0];
        if (sat_mode == MODE_CLIP) begin
            if (w_clip < 0)
                sat_y = '0;
            else if (w_sat > w_clip)
                sat_y = w_clip[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/relu_act_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | relu_act_pipe: 2-stage multi-lane activation with sat counter     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module relu_act_pipe
    import relu_act_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_load,
    input  logic [1:0]             cfg_mode,
    input  logic [OUT_W-1:0]       cfg_clip,
    input  logic [2:0]             cfg_shift,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       sat_cnt
);

    localparam int POP_W = $clog2(LANES + 1);
    localparam logic [CFG_CLIP_W-1:0] C_CLIP_RST = CFG_CLIP_W'((1 << (OUT_W - 1)) - 1);

    act_cfg_t                r_cfg;
    logic                    r_v1;
    logic [LANES*IN_W-1:0]   r_a1;
    logic [1:0]              r_mode1;
    logic [CFG_CLIP_W-1:0]   r_clip1;
    logic                    r_v2;
    logic [LANES*OUT_W-1:0]  r_d2;
    logic [LANES-1:0]        r_sat2;
    logic [CNT_W-1:0]        r_cnt;

    logic [LANES*IN_W-1:0]   w_a;
    logic [LANES*OUT_W-1:0]  w_y;
    logic [LANES-1:0]        w_sat;
    logic                    w_ld1;
    logic                    w_ld2;
    logic [POP_W-1:0]        w_pop;
    logic [CNT_W:0]          w_sum;

    assign w_ld2     = !r_v2 || out_ready;
    assign w_ld1     = !r_v1 || w_ld2;
    assign in_ready  = !r_v1 || !r_v2 || out_ready;
    assign out_valid = r_v2;
    assign out_data  = r_d2;
    assign sat_cnt   = r_cnt;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            relu_act_lane #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_lane (
                .act_x     (in_data[i*IN_W +: IN_W]),
                .act_mode  (r_cfg.mode),
                .act_shift (r_cfg.shift),
                .act_a     (w_a[i*IN_W +: IN_W]),
                .sat_a     (r_a1[i*IN_W +: IN_W]),
                .sat_mode  (r_mode1),
                .sat_clip  (r_clip1),
                .sat_y     (w_y[i*OUT_W +: OUT_W]),
                .sat_flag  (w_sat[i])
            );
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++)
            w_pop = w_pop + POP_W'(r_sat2[i]);
    end

    assign w_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_pop);

    // Stage 1 samples the active config before a same-edge cfg_load lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg.mode  <= MODE_RELU;
            r_cfg.clip  <= C_CLIP_RST;
            r_cfg.shift <= '0;
            r_v1        <= 1'b0;
            r_a1        <= '0;
            r_mode1     <= MODE_RELU;
            r_clip1     <= C_CLIP_RST;
            r_v2        <= 1'b0;
            r_d2        <= '0;
            r_sat2      <= '0;
            r_cnt       <= '0;
        end else begin
            if (cfg_load) begin
                r_cfg.mode  <= cfg_mode;
                r_cfg.clip  <= {{(CFG_CLIP_W-OUT_W){cfg_clip[OUT_W-1]}}, cfg_clip};
                r_cfg.shift <= cfg_shift;
            end
            if (w_ld1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_a1    <= w_a;
                    r_mode1 <= r_cfg.mode;
                    r_clip1 <= r_cfg.clip;
                end
            end
            if (w_ld2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2   <= w_y;
                    r_sat2 <= w_sat;
                end
            end
            if (cnt_clr)
                r_cnt <= '0;
            else if (r_v2 && out_ready)
                r_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_relu_act_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_relu_act_pipe: directed self-checking bench for relu_act_pipe  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_relu_act_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int LANES = 4;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_load = 1'b0;
    logic [1:0]             cfg_mode = 2'd0;
    logic [OUT_W-1:0]       cfg_clip = '0;
    logic [2:0]             cfg_shift = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [LANES*OUT_W-1:0] out_data;
    logic                   cnt_clr = 1'b0;
    logic [CNT_W-1:0]       sat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    relu_act_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_mode  (cfg_mode),
        .cfg_clip  (cfg_clip),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .sat_cnt   (sat_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [7:0] c, input logic [2:0] s);
        @(negedge clk);
        cfg_load  = 1'b1;
        cfg_mode  = m;
        cfg_clip  = c;
        cfg_shift = s;
        @(posedge clk);
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Accept one beat, then expect it on the output two cycles after the accept cycle.
    task automatic send_check(input string tag, input logic [63:0] din, input logic [31:0] dexp);
        @(negedge clk);
        in_data  = din;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_vld"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(dexp));
    endtask

    function automatic logic [63:0] bp_in(input int k);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++)
            v[i*IN_W +: IN_W] = 16'(k*4 + i - 20);
        return v;
    endfunction

    function automatic logic [31:0] bp_exp(input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++)
            v[i*OUT_W +: OUT_W] = 8'(k*4 + i - 20);
        return v;
    endfunction

    initial begin
        int  n_in;
        int  n_out;
        logic acc;
        logic xf;

        // Reset state
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Default mode is ReLU
        send_check("relu", {16'h0000, 16'h0200, 16'h0050, 16'hFF80}, 32'h007F5000);
        @(negedge clk);
        check("relu_cnt", 64'(sat_cnt), 64'd1);

        // Clipped ReLU
        set_cfg(2'd2, 8'd6, 3'd0);
        send_check("clip6", {16'h0006, 16'hFFFB, 16'h000A, 16'h0003}, 32'h06000603);
        @(negedge clk);
        check("clip6_cnt", 64'(sat_cnt), 64'd1);
        set_cfg(2'd2, 8'hFC, 3'd0);
        send_check("clipneg", {16'h0006, 16'hFFFB, 16'h000A, 16'h0003}, 32'h00000000);

        // Leaky ReLU, slope 1/4
        set_cfg(2'd3, 8'h7F, 3'd2);
        send_check("leaky", {16'hFFFF, 16'h0064, 16'hFC18, 16'hFFF7}, 32'hFF6480FD);
        @(negedge clk);
        check("leaky_cnt", 64'(sat_cnt), 64'd2);

        // Backpressure: out_ready low for the first 3 cycles, 10 beats in bypass
        set_cfg(2'd0, 8'h7F, 3'd0);
        n_in  = 0;
        n_out = 0;
        @(negedge clk);
        for (int c = 0; c < 40 && n_out < 10; c++) begin
            out_ready = (c >= 3);
            in_valid  = (n_in < 10);
            in_data   = bp_in(n_in);
            #1;
            if (c == 2) begin
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_accepts", 64'(n_in), 64'd2);
            end
            if (out_valid)
                check($sformatf("bp_data%0d", n_out), 64'(out_data), 64'(bp_exp(n_out)));
            else if (c >= 2)
                check("bp_gap", 64'(out_valid), 64'd1);
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            @(posedge clk);
            if (acc) n_in++;
            if (xf) n_out++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 64'(n_out), 64'd10);
        check("bp_cnt", 64'(sat_cnt), 64'd2);

        // cfg_load in the accept cycle: first beat sees bypass, second ReLU
        @(negedge clk);
        cfg_load  = 1'b1;
        cfg_mode  = 2'd1;
        cfg_clip  = 8'h7F;
        cfg_shift = 3'd0;
        in_valid  = 1'b1;
        in_data   = {4{16'hFFFB}};
        @(posedge clk);
        @(negedge clk);
        cfg_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("cfg_old_vld", 64'(out_valid), 64'd1);
        check("cfg_old_data", 64'(out_data), 64'hFBFBFBFB);
        @(negedge clk);
        check("cfg_new_vld", 64'(out_valid), 64'd1);
        check("cfg_new_data", 64'(out_data), 64'h00000000);

        // Drive the counter to 0xFFFE with 16383 beats of 4 saturating lanes
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {4{16'h7FFF}};
        repeat (16383) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("preload_cnt", 64'(sat_cnt), 64'hFFFE);

        send_check("sat3", {16'h0001, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 32'h017F7F7F);
        @(negedge clk);
        check("sat3_cnt", 64'(sat_cnt), 64'hFFFF);
        send_check("sticky", {16'h0001, 16'h0001, 16'h0001, 16'h7FFF}, 32'h0101017F);
        @(negedge clk);
        check("sticky_cnt", 64'(sat_cnt), 64'hFFFF);

        send_check("clr", {4{16'h7FFF}}, 32'h7F7F7F7F);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_cnt", 64'(sat_cnt), 64'd0);

        // Asynchronous reset in the middle of a stream
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {4{16'h0010}};
        repeat (3) @(posedge clk);
        #1;
        check("mid_pre_vld", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_no_stale%0d", k), 64'(out_valid), 64'd0);
        end

        // Config is back to ReLU after reset
        send_check("post_rst", {16'h0200, 16'hFFFB, 16'h0005, 16'hFFFB}, 32'h7F000500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
